microc_stack: RTL

Parametrised single-cycle microcontroller datapath, successor to the fixed 8-bit/10-bit-PC core. It adds configurable data and PC widths, a hardware return-address stack for call/return, and a carry flag alongside the zero flag. Program memory sits outside the block: it drives `pc` and receives `instr` from an asynchronous-read ROM. The existing control unit decodes `Opcode` and drives the control inputs.

---
 rtl/microc_stack.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/microc_stack.sv
// microc_stack -- single-cycle microcontroller datapath with a return-address stack.
//
// One instruction per clock. Program memory is outside the block: `pc` addresses an
// asynchronous-read ROM whose word comes back on `instr` in the same cycle. An external
// control unit decodes `Opcode` and drives the control inputs.
//
// Parameters
//   DW          data width of registers, ALU and immediate (>= 4)
//   PCW         program counter width (PCW <= DW+2)
//   STACK_DEPTH return-address stack entries (>= 1)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears pc, sp, z, c and the sticky stack flags
//   instr      instruction word (DW+8 bits) at `pc`
//   s_inc      1: pc increments, 0: pc loads the jump target
//   s_inm      1: register write data is the immediate, 0: the ALU result
//   we3        register file write enable
//   wez, wec   zero / carry flag write enables
//   Op         ALU operation
//   push, pop  call / return
//   pc         current program counter
//   Opcode     instr[IW-1:IW-6]
//   z, c       registered zero and carry/borrow flags
//   stack_ovf  sticky: push while the stack was full
//   stack_unf  sticky: pop while the stack was empty
module microc_stack #(
   parameter int DW          = 8,
   parameter int PCW         = 10,
   parameter int STACK_DEPTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [DW+7:0]  instr,
   input  logic           s_inc,
   input  logic           s_inm,
   input  logic           we3,
   input  logic           wez,
   input  logic           wec,
   input  logic [2:0]     Op,
   input  logic           push,
   input  logic           pop,
   output logic [PCW-1:0] pc,
   output logic [5:0]     Opcode,
   output logic           z,
   output logic           c,
   output logic           stack_ovf,
   output logic           stack_unf
);

   localparam int IW   = DW + 8;
   // sp must represent 0..STACK_DEPTH inclusive, so it needs one more code than the
   // entry index.
   localparam int SPW  = $clog2(STACK_DEPTH + 1);
   localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   // Instruction fields
   logic [3:0]     ra1, ra2, wa3;
   logic [DW-1:0]  imm;
   logic [PCW-1:0] jtarget;

   assign ra1     = instr[11:8];
   assign ra2     = instr[7:4];
   assign wa3     = instr[3:0];
   assign imm     = instr[DW+3:4];
   assign jtarget = instr[PCW-1:0];
   assign Opcode  = instr[IW-1:IW-6];

   // State
   logic [DW-1:0]  rf_q  [16];
   logic [PCW-1:0] stk_q [STACK_DEPTH];
   logic [PCW-1:0] pc_q, pc_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic           z_q, z_d;
   logic           c_q, c_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;

   // Register file reads: r0 is hard-wired to zero whatever was written to it.
   logic [DW-1:0] rd1, rd2;
   assign rd1 = (ra1 == 4'd0) ? '0 : rf_q[ra1];
   assign rd2 = (ra2 == 4'd0) ? '0 : rf_q[ra2];

   // ALU, evaluated one bit wider so add carry-out and subtract borrow land in bit DW.
   logic [DW:0]   alu_x;
   logic [DW-1:0] alu_res;
   logic          alu_zero;
   logic          alu_carry;

   always_comb begin
      alu_x = '0;
      case (Op)
         3'b000:  alu_x = {1'b0, rd1};
         3'b001:  alu_x = {1'b0, ~rd1};
         3'b010:  alu_x = {1'b0, rd1} + {1'b0, rd2};
         3'b011:  alu_x = {1'b0, rd1} - {1'b0, rd2};
         3'b100:  alu_x = {1'b0, rd1 & rd2};
         3'b101:  alu_x = {1'b0, rd1 | rd2};
         3'b110:  alu_x = {1'b0, DW'(-rd1)};
         default: alu_x = {1'b0, DW'(-rd2)};
      endcase
   end

   assign alu_res   = alu_x[DW-1:0];
   assign alu_zero  = (alu_res == '0);
   assign alu_carry = ((Op == 3'b010) || (Op == 3'b011)) ? alu_x[DW] : 1'b0;

   logic [DW-1:0] wd3;
   assign wd3 = s_inm ? imm : alu_res;

   // Next PC and return stack
   logic [PCW-1:0]  pc_inc;
   logic            stk_empty, stk_full, stk_we;
   logic [IDXW-1:0] top_idx, wr_idx;

   assign pc_inc    = pc_q + PCW'(1);
   assign stk_empty = (sp_q == '0);
   assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
   assign top_idx   = IDXW'(sp_q - SPW'(1));
   assign wr_idx    = IDXW'(sp_q);

   always_comb begin
      pc_d   = s_inc ? pc_inc : jtarget;
      sp_d   = sp_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      stk_we = 1'b0;
      // pop outranks push; a simultaneous push is dropped entirely.
      if (pop) begin
         if (!stk_empty) begin
            pc_d = stk_q[top_idx];
            sp_d = sp_q - SPW'(1);
         end else begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
         end
      end else if (push) begin
         if (!stk_full) begin
            stk_we = 1'b1;
            sp_d   = sp_q + SPW'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // Flags follow the ALU even when the immediate is being written.
   assign z_d = wez ? alu_zero  : z_q;
   assign c_d = wec ? alu_carry : c_q;

   // Control state: reset applies here only.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= '0;
         sp_q  <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         z_q   <= z_d;
         c_q   <= c_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Data storage: never reset, but writes are suppressed while reset is asserted so
   // reset dominates every other input in that cycle.
   always_ff @(posedge clk) begin
      if (!reset && we3 && (wa3 != 4'd0)) rf_q[wa3] <= wd3;
      if (!reset && stk_we)               stk_q[wr_idx] <= pc_inc;
   end

   assign pc        = pc_q;
   assign z         = z_q;
   assign c         = c_q;
   assign stack_ovf = ovf_q;
   assign stack_unf = unf_q;

endmodule
